// File: rtl/amm_pkg.sv
// Shared defaults, state type and helpers for the Avalon-MM write master.
package amm_pkg;

    localparam int unsigned DEFAULT_ADDRESSWIDTH = 28;
    localparam int unsigned DEFAULT_DATAWIDTH    = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 32;
    localparam int unsigned BYTES_PER_WORD       = DEFAULT_DATAWIDTH / 8;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/amm_write_master_if.sv
// Control, user write-buffer and Avalon-MM signals of the write master, seen from both sides.
interface amm_write_master_if
    import amm_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH,
    parameter int unsigned DATAWIDTH    = DEFAULT_DATAWIDTH
);

    logic                      control_fixed_location;
    logic [ADDRESSWIDTH-1:0]   control_write_base;
    logic [ADDRESSWIDTH-1:0]   control_write_length;
    logic                      control_go;
    logic                      control_done;

    logic                      user_write_buffer;
    logic [DATAWIDTH-1:0]      user_buffer_data;
    logic                      user_buffer_full;

    logic [ADDRESSWIDTH-1:0]   master_address;
    logic                      master_write;
    logic [DATAWIDTH/8-1:0]    master_byteenable;
    logic [DATAWIDTH-1:0]      master_writedata;
    logic                      master_waitrequest;

    modport master (
        input  control_fixed_location,
        input  control_write_base,
        input  control_write_length,
        input  control_go,
        output control_done,
        input  user_write_buffer,
        input  user_buffer_data,
        output user_buffer_full,
        output master_address,
        output master_write,
        output master_byteenable,
        output master_writedata,
        input  master_waitrequest
    );

    modport slave (
        output control_fixed_location,
        output control_write_base,
        output control_write_length,
        output control_go,
        input  control_done,
        output user_write_buffer,
        output user_buffer_data,
        input  user_buffer_full,
        input  master_address,
        input  master_write,
        input  master_byteenable,
        input  master_writedata,
        output master_waitrequest
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head_data is the oldest word whenever empty is low.
module sync_fifo #(
    parameter int unsigned  WIDTH = 32,
    parameter int unsigned  DEPTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/amm_write_master.sv
// Avalon-MM write master: buffers user words and writes them one per beat to base..base+length.
module amm_write_master
    import amm_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH,
    parameter int unsigned DATAWIDTH    = DEFAULT_DATAWIDTH,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input logic                clk,
    input logic                n_rst,
    amm_write_master_if.master bus
);

    localparam int unsigned BPW   = bytes_per_word(DATAWIDTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDRESSWIDTH-1:0] WORD_STEP = ADDRESSWIDTH'(BPW);
    localparam logic [ADDRESSWIDTH-1:0] LEN_MASK  = ~ADDRESSWIDTH'(BPW - 1);

    state_e                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [ADDRESSWIDTH-1:0] remaining_q, remaining_d;
    logic                    fixed_q, fixed_d;
    logic [ADDRESSWIDTH-1:0] job_len;

    logic                    write_req;
    logic                    accept;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATAWIDTH-1:0]    fifo_head;

    sync_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (bus.user_write_buffer),
        .push_data (bus.user_buffer_data),
        .pop       (accept),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Derived only from state and FIFO count registers, so it is glitch-free and
    // drops on the same edge that retires the last word of the job.
    assign write_req = (state_q == RUN) && !fifo_empty;
    assign accept    = write_req && !bus.master_waitrequest;
    assign job_len   = bus.control_write_length & LEN_MASK;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        fixed_d     = fixed_q;
        unique case (state_q)
            IDLE: begin
                if (bus.control_go) begin
                    addr_d      = bus.control_write_base;
                    remaining_d = job_len;
                    fixed_d     = bus.control_fixed_location;
                    if (job_len != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // control_go is deliberately ignored here; the running job stays intact.
                if (accept) begin
                    remaining_d = remaining_q - WORD_STEP;
                    if (!fixed_q) begin
                        addr_d = addr_q + WORD_STEP;
                    end
                    if (remaining_q == WORD_STEP) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            fixed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            fixed_q     <= fixed_d;
        end
    end

    assign bus.control_done      = (state_q == IDLE);
    assign bus.user_buffer_full  = fifo_full;
    assign bus.master_address    = addr_q;
    assign bus.master_write      = write_req;
    assign bus.master_byteenable = '1;
    assign bus.master_writedata  = fifo_head;

    // FIFO bookkeeping consistency: empty flag and occupancy must never disagree.
    assert property (@(posedge clk) disable iff (!n_rst)
        (fifo_empty == (fifo_count == '0)) && (fifo_count <= CNT_W'(FIFO_DEPTH)));

endmodule
